// File: rtl/cbus_arbiter.sv
// Cache-bus arbiter: one requester at a time owns the memory-side cbus for a whole burst.
// Requests and responses pass through combinationally while the grant is held.
package cbus_arbiter_pkg;

   typedef struct packed {
      logic        valid;
      logic        is_write;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [3:0]  strobe;
      logic [31:0] data;
      logic [7:0]  len;
   } cbus_req_t;

   typedef struct packed {
      logic        ready;
      logic        last;
      logic [31:0] data;
   } cbus_resp_t;

endpackage

// state   | meaning
// S_IDLE  | no grant held; pick a winner among valid requests
// S_GRANT | r_sel owns the bus until a beat with ready && last
module cbus_arbiter
   import cbus_arbiter_pkg::*;
#(
   parameter int N_REQ      = 2,
   parameter bit FIXED_PRIO = 1'b0,
   localparam int SEL_W     = $clog2(N_REQ)
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  cbus_req_t  [N_REQ-1:0] ireqs,
   output cbus_resp_t [N_REQ-1:0] oresps,
   output cbus_req_t              oreq,
   input  cbus_resp_t             iresp,
   output logic                   busy,
   output logic [SEL_W-1:0]       grant
);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_GRANT = 1'b1
   } state_t;

   localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_REQ - 1);
   localparam logic [SEL_W:0]   N_EXT    = (SEL_W + 1)'(N_REQ);

   state_t               r_state;
   state_t               w_state_nxt;
   logic [SEL_W-1:0]     r_sel;
   logic [SEL_W-1:0]     w_sel_nxt;
   logic [SEL_W-1:0]     r_rr_ptr;
   logic [SEL_W-1:0]     w_rr_nxt;
   logic [SEL_W-1:0]     w_start;
   logic [SEL_W-1:0]     w_off;
   logic [SEL_W-1:0]     w_win;
   logic [SEL_W:0]       w_sum;
   logic [N_REQ-1:0]     w_valid;
   logic [N_REQ-1:0]     w_rot;
   logic [2*N_REQ-1:0]   w_dbl;
   logic                 w_any;
   logic                 w_done;

   always_comb begin
      w_valid = '0;
      for (int i = 0; i < N_REQ; i++) w_valid[i] = ireqs[i].valid;
   end

   // Rotating a doubled copy puts the scan start at bit 0, so the lowest set
   // bit is the offset of the winner from the start index.
   assign w_start = FIXED_PRIO ? '0 : r_rr_ptr;
   assign w_dbl   = {w_valid, w_valid} >> w_start;
   assign w_rot   = w_dbl[N_REQ-1:0];
   assign w_any   = |w_valid;

   always_comb begin
      w_off = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (w_rot[k]) w_off = SEL_W'(k);
      end
   end

   assign w_sum  = {1'b0, w_start} + {1'b0, w_off};
   assign w_win  = (w_sum >= N_EXT) ? SEL_W'(w_sum - N_EXT) : SEL_W'(w_sum);
   assign w_done = iresp.ready & iresp.last;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state  <= S_IDLE;
         r_sel    <= '0;
         r_rr_ptr <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_sel    <= w_sel_nxt;
         r_rr_ptr <= w_rr_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_sel_nxt   = r_sel;
      w_rr_nxt    = r_rr_ptr;
      oreq        = '0;
      oresps      = '0;
      busy        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_any) begin
               w_state_nxt = S_GRANT;
               w_sel_nxt   = w_win;
            end
         end
         S_GRANT: begin
            busy          = 1'b1;
            oreq          = ireqs[r_sel];
            oresps[r_sel] = iresp;
            if (w_done) begin
               w_state_nxt = S_IDLE;
               w_rr_nxt    = (r_sel == LAST_IDX) ? '0 : r_sel + 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign grant = r_sel;

endmodule

// File: tb/tb_cbus_arbiter.sv
// Scoreboard bench for cbus_arbiter: round-robin, fixed-priority and 3-requester instances.
// Stimulus pushes expected grants/beats; negedge monitors pop and compare.
module tb_cbus_arbiter;
   import cbus_arbiter_pkg::*;

   typedef struct {
      logic [31:0] addr;
      logic [7:0]  len;
      int          drop_at;
   } rq_t;

   typedef struct {
      int          idx;
      logic [31:0] data;
      logic        last;
   } beat_t;

   typedef struct {
      int          idx;
      logic [31:0] addr;
      logic [7:0]  len;
   } gnt_t;

   logic clk    = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   cbus_req_t  [1:0] rr_ireqs  = '0;
   cbus_resp_t [1:0] rr_oresps;
   cbus_req_t        rr_oreq;
   cbus_resp_t       rr_iresp  = '0;
   logic             rr_busy;
   logic [0:0]       rr_grant;

   cbus_req_t  [1:0] fp_ireqs  = '0;
   cbus_resp_t [1:0] fp_oresps;
   cbus_req_t        fp_oreq;
   cbus_resp_t       fp_iresp  = '0;
   logic             fp_busy;
   logic [0:0]       fp_grant;

   cbus_req_t  [2:0] n3_ireqs  = '0;
   cbus_resp_t [2:0] n3_oresps;
   cbus_req_t        n3_oreq;
   cbus_resp_t       n3_iresp  = '0;
   logic             n3_busy;
   logic [1:0]       n3_grant;

   cbus_arbiter #(.N_REQ(2), .FIXED_PRIO(1'b0)) dut_rr (
      .clk(clk), .resetn(resetn), .ireqs(rr_ireqs), .oresps(rr_oresps),
      .oreq(rr_oreq), .iresp(rr_iresp), .busy(rr_busy), .grant(rr_grant));

   cbus_arbiter #(.N_REQ(2), .FIXED_PRIO(1'b1)) dut_fp (
      .clk(clk), .resetn(resetn), .ireqs(fp_ireqs), .oresps(fp_oresps),
      .oreq(fp_oreq), .iresp(fp_iresp), .busy(fp_busy), .grant(fp_grant));

   cbus_arbiter #(.N_REQ(3), .FIXED_PRIO(1'b0)) dut_n3 (
      .clk(clk), .resetn(resetn), .ireqs(n3_ireqs), .oresps(n3_oresps),
      .oreq(n3_oreq), .iresp(n3_iresp), .busy(n3_busy), .grant(n3_grant));

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name, input string what);
      checks++;
      failures++;
      $display("FAIL %s: got %s expected none", name, what);
   endtask

   function automatic cbus_req_t mk_req(input logic [31:0] addr, input logic [7:0] len);
      cbus_req_t q;
      q        = '0;
      q.valid  = 1'b1;
      q.size   = 3'd2;
      q.addr   = addr;
      q.strobe = 4'hF;
      q.data   = ~addr;
      q.len    = len;
      return q;
   endfunction

   // ---------------- scoreboard queues ----------------
   rq_t   req_q0[$];
   rq_t   req_q1[$];
   beat_t exp_q[$];
   gnt_t  gq[$];
   int    fp_gq[$];
   int    n3_gq[$];
   int    mem_wait = 0;

   task automatic exp_burst(input int idx, input logic [31:0] addr, input int len, input int nbeats);
      gq.push_back('{idx: idx, addr: addr, len: 8'(len)});
      for (int k = 0; k < nbeats; k++)
         exp_q.push_back('{idx: idx, data: addr + 32'(k), last: (k == len)});
   endtask

   // ---------------- requester + memory model for dut_rr ----------------
   initial begin
      bit          popf [2];
      int          seen [2];
      logic        bd;
      int          cnt;
      int          wt;
      logic [31:0] cur_addr;
      logic [7:0]  cur_len;
      popf = '{0, 0};
      seen = '{0, 0};
      bd = 1'b0; cnt = 0; wt = 0; cur_addr = '0; cur_len = '0;
      forever begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            if (rr_oresps[i].ready) begin
               seen[i]++;
               if (rr_oresps[i].last) popf[i] = 1'b1;
            end
         end
         @(posedge clk);
         #1;
         if (rr_busy) begin
            if (!bd) begin
               cur_addr = rr_oreq.addr;
               cur_len  = rr_oreq.len;
               cnt      = 0;
               wt       = mem_wait;
            end
            if (wt > 0) begin
               wt--;
               rr_iresp = '0;
            end else begin
               rr_iresp.ready = 1'b1;
               rr_iresp.last  = (cnt == int'(cur_len));
               rr_iresp.data  = cur_addr + 32'(cnt);
               cnt++;
            end
         end else begin
            // memory noise while idle must never reach a requester
            rr_iresp.ready = 1'b1;
            rr_iresp.last  = 1'b1;
            rr_iresp.data  = 32'hDEAD_BEEF;
         end
         bd = rr_busy;
         if (popf[0]) begin popf[0] = 1'b0; seen[0] = 0; if (req_q0.size() > 0) req_q0.delete(0); end
         if (popf[1]) begin popf[1] = 1'b0; seen[1] = 0; if (req_q1.size() > 0) req_q1.delete(0); end
         if (req_q0.size() == 0) seen[0] = 0;
         if (req_q1.size() == 0) seen[1] = 0;
         rr_ireqs[0] = (req_q0.size() > 0 && seen[0] < req_q0[0].drop_at) ?
                       mk_req(req_q0[0].addr, req_q0[0].len) : '0;
         rr_ireqs[1] = (req_q1.size() > 0 && seen[1] < req_q1[0].drop_at) ?
                       mk_req(req_q1[0].addr, req_q1[0].len) : '0;
      end
   end

   // ---------------- drivers for dut_fp / dut_n3 (single-beat memory) ----------------
   logic [1:0] fp_valid = '0;
   logic [2:0] n3_valid = '0;

   initial begin
      forever begin
         @(posedge clk);
         #1;
         fp_iresp = '0;
         if (fp_busy) begin fp_iresp.ready = 1'b1; fp_iresp.last = 1'b1; fp_iresp.data = 32'h0F0; end
         n3_iresp = '0;
         if (n3_busy) begin n3_iresp.ready = 1'b1; n3_iresp.last = 1'b1; n3_iresp.data = 32'h0F3; end
         for (int i = 0; i < 2; i++)
            fp_ireqs[i] = fp_valid[i] ? mk_req(32'h8000 + 32'(i * 16), 8'd0) : '0;
         for (int i = 0; i < 3; i++)
            n3_ireqs[i] = n3_valid[i] ? mk_req(32'h9000 + 32'(i * 16), 8'd0) : '0;
      end
   end

   // ---------------- monitors ----------------
   logic  mon_bd  = 1'b0;
   logic  mon_idl = 1'b0;
   logic  fp_bd   = 1'b0;
   logic  n3_bd   = 1'b0;
   gnt_t  mg;
   beat_t mb;
   int    mi;

   always @(negedge clk) begin
      if (mon_idl) chk("rr_idle_after_last", rr_busy, 1'b0);
      mon_idl = 1'b0;
      if (rr_busy && !mon_bd) begin
         if (gq.size() == 0) fail_now("rr_grant_event", "unexpected grant");
         else begin
            mg = gq.pop_front();
            chk("rr_grant", rr_grant, mg.idx);
            chk("rr_oreq_valid", rr_oreq.valid, 1'b1);
            chk("rr_oreq_addr", rr_oreq.addr, mg.addr);
            chk("rr_oreq_len", rr_oreq.len, mg.len);
            chk("rr_oreq_data", rr_oreq.data, ~mg.addr);
         end
      end
      for (int i = 0; i < 2; i++) begin
         if (rr_oresps[i].ready) begin
            if (exp_q.size() == 0) fail_now("rr_beat_event", "unexpected beat");
            else begin
               mb = exp_q.pop_front();
               chk("rr_beat_idx", i, mb.idx);
               chk("rr_beat_data", rr_oresps[i].data, mb.data);
               chk("rr_beat_last", rr_oresps[i].last, mb.last);
            end
            if (rr_oresps[i].last) mon_idl = 1'b1;
         end
      end
      mon_bd = rr_busy;

      if (fp_busy && !fp_bd) begin
         if (fp_gq.size() == 0) fail_now("fp_grant_event", "unexpected grant");
         else begin
            mi = fp_gq.pop_front();
            chk("fp_grant", fp_grant, mi);
            chk("fp_oreq_addr", fp_oreq.addr, 32'h8000 + 32'(mi * 16));
         end
      end
      fp_bd = fp_busy;

      if (n3_busy && !n3_bd) begin
         if (n3_gq.size() == 0) fail_now("n3_grant_event", "unexpected grant");
         else begin
            mi = n3_gq.pop_front();
            chk("n3_grant", n3_grant, mi);
            chk("n3_oreq_addr", n3_oreq.addr, 32'h9000 + 32'(mi * 16));
         end
      end
      n3_bd = n3_busy;
   end

   // ---------------- wait helpers (bounded) ----------------
   task automatic wait_done(input string name, input int budget);
      int n = 0;
      while (!(exp_q.size() == 0 && gq.size() == 0 && req_q0.size() == 0 &&
               req_q1.size() == 0 && !rr_busy) && n < budget) begin
         @(negedge clk); #2; n++;
      end
      if (n >= budget) fail_now(name, "timeout");
   endtask

   task automatic wait_sb(input string name, input int budget);
      int n = 0;
      while (!(exp_q.size() == 0 && gq.size() == 0) && n < budget) begin
         @(negedge clk); #2; n++;
      end
      if (n >= budget) fail_now(name, "timeout");
   endtask

   task automatic wait_fp(input string name, input int budget);
      int n = 0;
      while (fp_gq.size() != 0 && n < budget) begin @(negedge clk); #2; n++; end
      if (n >= budget) fail_now(name, "timeout");
   endtask

   task automatic wait_n3(input string name, input int budget);
      int n = 0;
      while (n3_gq.size() != 0 && n < budget) begin @(negedge clk); #2; n++; end
      if (n >= budget) fail_now(name, "timeout");
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      // reset held with a pending request on requester 0
      req_q0.push_back('{addr: 32'h100, len: 8'd0, drop_at: 255});
      exp_burst(0, 32'h100, 0, 1);
      repeat (3) @(negedge clk);
      #2;
      chk("rst_oreq_valid", rr_oreq.valid, 1'b0);
      chk("rst_busy", rr_busy, 1'b0);
      chk("rst_grant", rr_grant, 1'b0);
      chk("rst_oresps_nonzero", (rr_oresps != '0), 1'b0);
      resetn = 1'b1;
      #1;
      chk("rel_oreq_valid_same_cycle", rr_oreq.valid, 1'b0);
      @(posedge clk);
      #1;
      chk("rel_oreq_valid_after_arb", rr_oreq.valid, 1'b1);
      chk("rel_grant", rr_grant, 1'b0);
      wait_done("t1_done", 40);

      // 16-beat burst on requester 0
      req_q0.push_back('{addr: 32'h2000, len: 8'd15, drop_at: 255});
      exp_burst(0, 32'h2000, 15, 16);
      wait_done("t3_done", 80);

      // single read on requester 1, memory answers in 2nd grant cycle
      mem_wait = 1;
      req_q1.push_back('{addr: 32'h1000, len: 8'd0, drop_at: 255});
      exp_burst(1, 32'h1000, 0, 1);
      wait_done("t2_done", 40);
      mem_wait = 0;

      // round-robin contention, requester 1 drops valid mid-burst on its 2nd burst
      req_q0.push_back('{addr: 32'h3000, len: 8'd3, drop_at: 255});
      req_q0.push_back('{addr: 32'h3100, len: 8'd3, drop_at: 255});
      req_q1.push_back('{addr: 32'h4000, len: 8'd3, drop_at: 255});
      req_q1.push_back('{addr: 32'h4100, len: 8'd3, drop_at: 2});
      exp_burst(0, 32'h3000, 3, 4);
      exp_burst(1, 32'h4000, 3, 4);
      exp_burst(0, 32'h3100, 3, 4);
      exp_burst(1, 32'h4100, 3, 4);
      wait_done("t4_done", 120);

      // async reset at beat 5 of a 16-beat burst; rr_ptr must return to 0
      req_q0.push_back('{addr: 32'h5000, len: 8'd0, drop_at: 255});
      exp_burst(0, 32'h5000, 0, 1);
      wait_done("t6a_done", 40);
      req_q1.push_back('{addr: 32'h6000, len: 8'd15, drop_at: 255});
      exp_burst(1, 32'h6000, 15, 5);
      wait_sb("t6_beat5", 60);
      resetn = 1'b0;
      #1;
      chk("midrst_oreq_valid", rr_oreq.valid, 1'b0);
      chk("midrst_busy", rr_busy, 1'b0);
      chk("midrst_oresps_nonzero", (rr_oresps != '0), 1'b0);
      req_q1.delete();
      @(negedge clk);
      #2;
      resetn = 1'b1;
      req_q0.push_back('{addr: 32'h7000, len: 8'd0, drop_at: 255});
      req_q1.push_back('{addr: 32'h7100, len: 8'd0, drop_at: 255});
      exp_burst(0, 32'h7000, 0, 1);
      exp_burst(1, 32'h7100, 0, 1);
      wait_done("t6_done", 60);

      // fixed priority: 0 starves 1 until it drops
      fp_gq.push_back(0); fp_gq.push_back(0); fp_gq.push_back(0);
      fp_valid = 2'b11;
      wait_fp("fp_stay0", 40);
      fp_gq.push_back(1);
      fp_valid = 2'b10;
      wait_fp("fp_then1", 40);
      fp_valid = 2'b00;

      // three requesters, round-robin wraps 2 -> 0
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < 3; i++) n3_gq.push_back(i);
      n3_valid = 3'b111;
      wait_n3("n3_seq", 60);
      n3_valid = 3'b000;

      repeat (6) @(negedge clk);
      #2;
      chk("end_rr_exp_left", exp_q.size(), 0);
      chk("end_fp_busy", fp_busy, 1'b0);
      chk("end_n3_busy", n3_busy, 1'b0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
